pattern_sequencer: RTL and testbench

Frame/line timing controller and configuration scheduler for the pattern generator. Holds a 4-entry program table, each entry giving Mode, X, Y, constVal and a repeat count. It generates the f_sync/sync pulse train that drives the generator's counting and applies each entry's configuration only at frame boundaries. It steps through the table in a loop until stopped.

---
 rtl/pattern_sequencer.sv | 98 +++++++++
 tb/tb_pattern_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: frame/line sync generator that applies a 4-entry program table
// at frame boundaries, looping entries 0..last_idx with per-entry repeat counts.
module pattern_sequencer #(
  parameter int LINE_LEN = 16,
  parameter int LINES    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  last_idx,
  input  logic        cfg_wr,
  input  logic [1:0]  cfg_addr,
  input  logic [22:0] cfg_data,
  output logic        f_sync,
  output logic        sync,
  output logic [2:0]  Mode,
  output logic [1:0]  X,
  output logic [1:0]  Y,
  output logic [11:0] constVal,
  output logic        busy,
  output logic [1:0]  entry_idx,
  output logic        frame_done
);
  localparam logic [1:0] IDLE = 2'd0, FSYNC = 2'd1, LSYNC = 2'd2, ACTIVE = 2'd3;
  localparam int PW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
  logic [1:0]    state;
  logic [22:0]   tbl [4];
  logic [3:0]    rep_cnt;
  logic [1:0]    last_q;
  logic          stop_pend;
  logic [PW-1:0] px_cnt;
  logic [LW-1:0] line_cnt;
  logic          line_end, frame_end, rep_hit;
  logic [1:0]    next_idx;
  assign line_end  = state == ACTIVE && px_cnt == PW'(LINE_LEN - 1);
  assign frame_end = line_end && line_cnt == LW'(LINES - 1);
  assign rep_hit   = rep_cnt == tbl[entry_idx][22:19];
  assign next_idx  = rep_hit ? (entry_idx == last_q ? 2'd0 : entry_idx + 2'd1) : entry_idx;
  assign f_sync    = state == FSYNC;
  assign sync      = state == LSYNC;
  assign busy      = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < 4; i++) tbl[i] <= '0;
    else if (cfg_wr) tbl[cfg_addr] <= cfg_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rep_cnt    <= '0;
      last_q     <= '0;
      stop_pend  <= 1'b0;
      px_cnt     <= '0;
      line_cnt   <= '0;
      entry_idx  <= '0;
      frame_done <= 1'b0;
      {Mode, X, Y, constVal} <= '0;
    end else begin
      frame_done <= frame_end;
      if (stop && state != IDLE) stop_pend <= 1'b1;
      case (state)
        IDLE: if (start) begin
          state     <= FSYNC;
          entry_idx <= 2'd0;
          rep_cnt   <= '0;
          last_q    <= last_idx;
          stop_pend <= 1'b0;
          {Mode, X, Y, constVal} <= tbl[0][18:0];
        end
        FSYNC: begin
          line_cnt <= '0;
          state    <= LSYNC;
        end
        LSYNC: begin
          px_cnt <= '0;
          state  <= ACTIVE;
        end
        default: begin
          px_cnt <= px_cnt + PW'(1);
          if (line_end && !frame_end) begin
            line_cnt <= line_cnt + LW'(1);
            state    <= LSYNC;
          end else if (frame_end && (stop_pend || stop)) begin
            state     <= IDLE;
            stop_pend <= 1'b0;
          end else if (frame_end) begin
            // config is reloaded every frame, so rewrites of the running entry land here
            rep_cnt   <= rep_hit ? 4'd0 : rep_cnt + 4'd1;
            entry_idx <= next_idx;
            {Mode, X, Y, constVal} <= tbl[next_idx][18:0];
            state     <= FSYNC;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: directed vector table and hand sequences plus randomized traffic,
// all cross-checked each cycle against a frame-position reference model.
module tb_pattern_sequencer;
  localparam int L = 16, N = 8, FL = 1 + N * (L + 1);
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, cfg_wr = 1'b0;
  logic [1:0] last_idx = 2'd0, cfg_addr = 2'd0;
  logic [22:0] cfg_data = '0;
  logic f_sync, sync, busy, frame_done;
  logic [2:0] Mode;
  logic [1:0] X, Y, entry_idx;
  logic [11:0] constVal;
  int vecs = 0, errs = 0;

  always #8 clk = ~clk;

  pattern_sequencer #(.LINE_LEN(L), .LINES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .last_idx(last_idx),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .f_sync(f_sync), .sync(sync), .Mode(Mode), .X(X), .Y(Y), .constVal(constVal),
    .busy(busy), .entry_idx(entry_idx), .frame_done(frame_done)
  );

  // reference: position within the frame plus the program table
  logic m_busy, m_sp, m_fd;
  int m_t;
  logic [1:0] m_ent, m_last, m_nx;
  logic [3:0] m_rep;
  logic [18:0] m_cfg;
  logic [22:0] m_tbl [4];
  logic m_hit, m_fend, e_fs, e_sy;
  assign m_hit  = m_rep == m_tbl[m_ent][22:19];
  assign m_nx   = m_hit ? (m_ent == m_last ? 2'd0 : m_ent + 2'd1) : m_ent;
  assign m_fend = m_busy && m_t == FL - 1;
  assign e_fs   = m_busy && m_t == 0;
  assign e_sy   = m_busy && m_t > 0 && (m_t - 1) % (L + 1) == 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_sp <= 1'b0; m_fd <= 1'b0; m_t <= 0;
      m_ent <= '0; m_last <= '0; m_rep <= '0; m_cfg <= '0;
      for (int i = 0; i < 4; i++) m_tbl[i] <= '0;
    end else begin
      m_fd <= m_fend;
      if (cfg_wr) m_tbl[cfg_addr] <= cfg_data;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1'b1; m_t <= 0; m_ent <= '0; m_rep <= '0;
          m_last <= last_idx; m_sp <= 1'b0; m_cfg <= m_tbl[0][18:0];
        end
      end else if (m_fend) begin
        if (m_sp || stop) m_busy <= 1'b0;
        else begin
          m_t <= 0; m_rep <= m_hit ? 4'd0 : m_rep + 4'd1;
          m_ent <= m_nx; m_cfg <= m_tbl[m_nx][18:0];
        end
      end else begin
        m_t <= m_t + 1;
        if (stop) m_sp <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("model", {7'd0, f_sync, sync, busy, entry_idx, frame_done, Mode, X, Y, constVal},
        {7'd0, e_fs, e_sy, m_busy, m_ent, m_fd, m_cfg});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [22:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic go(input logic [1:0] li, input logic with_stop);
    last_idx = li; start = 1'b1; stop = with_stop;
    tick();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin tick(); n++; end while (busy && n < 3 * FL);
  endtask

  task automatic quiet(input string nm, input int n);
    int fs = 0;
    for (int i = 0; i < n; i++) begin tick(); fs += int'(f_sync); end
    chk(nm, fs, 0);
  endtask

  typedef struct {
    int k;
    logic fs, sy, bz, fd;
    logic [1:0] ei;
    logic [11:0] cv;
  } vec_t;
  vec_t v[11];

  initial begin
    int k, n, syncs, fs2, fss;
    v[0]  = '{1,   1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'h111};
    v[1]  = '{2,   1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 12'h111};
    v[2]  = '{3,   1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 12'h111};
    v[3]  = '{19,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 12'h111};
    v[4]  = '{137, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 12'h111};
    v[5]  = '{138, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 12'h222};
    v[6]  = '{139, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 12'h222};
    v[7]  = '{275, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 12'h222};
    v[8]  = '{412, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 12'h333};
    v[9]  = '{549, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 12'h111};
    v[10] = '{550, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 12'h111};

    ticks(2);
    rst_n = 1'b1;
    tick();
    chk("reset_state", {busy, f_sync, sync, frame_done, entry_idx, Mode, X, Y, constVal}, 0);

    // zero table, single entry: sync spacing and frame period
    go(2'd0, 1'b0);
    chk("first_fsync", f_sync, 1);
    k = 1; syncs = 0; fs2 = 0;
    while (k < 2 * FL) begin
      tick(); k++;
      if (sync && k < 1 + FL) syncs++;
      if (f_sync && fs2 == 0) fs2 = k;
      if (sync && k == 2 + 7 * (L + 1)) chk("eighth_sync_pos", k, 121);
    end
    chk("sync_count", syncs, N);
    chk("fsync_period", fs2 - 1, FL);
    chk("zero_cfg", {Mode, X, Y, constVal}, 0);
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle(n);

    // three entries with repeats 0,1,0
    wr(2'd0, {4'd0, 3'd1, 2'd1, 2'd0, 12'h111});
    wr(2'd1, {4'd1, 3'd2, 2'd2, 2'd1, 12'h222});
    wr(2'd2, {4'd0, 3'd3, 2'd3, 2'd2, 12'h333});
    go(2'd2, 1'b0);
    k = 1;
    for (int i = 0; i < 11; i++) begin
      while (k < v[i].k) begin tick(); k++; end
      chk($sformatf("vec%0d_fsync", i), f_sync, v[i].fs);
      chk($sformatf("vec%0d_sync", i), sync, v[i].sy);
      chk($sformatf("vec%0d_busy", i), busy, v[i].bz);
      chk($sformatf("vec%0d_fdone", i), frame_done, v[i].fd);
      chk($sformatf("vec%0d_entry", i), entry_idx, v[i].ei);
      chk($sformatf("vec%0d_const", i), constVal, v[i].cv);
    end

    // stop mid-frame in line 3: frame completes then halts
    while (k < 610) begin tick(); k++; end
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle(n);
    chk("stop_latency", n, 75);
    chk("stop_fdone", frame_done, 1);
    quiet("stop_quiet", 200);

    // rewrite entry 1 while it is applied
    wr(2'd1, {4'd3, 3'd5, 2'd1, 2'd2, 12'h444});
    go(2'd1, 1'b0);
    k = 1;
    while (k < 200) begin tick(); k++; end
    wr(2'd1, {4'd3, 3'd5, 2'd1, 2'd2, 12'h555}); k++;
    while (k < 274) begin tick(); k++; end
    chk("rewrite_hold", constVal, 12'h444);
    tick(); k++;
    chk("rewrite_load", constVal, 12'h555);
    chk("rewrite_entry", entry_idx, 1);
    while (k < 686) begin tick(); k++; end
    chk("rewrite_wrap", entry_idx, 0);
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle(n);

    // start and stop together, then stop on the last active cycle
    go(2'd2, 1'b1);
    chk("ss_busy", busy, 1);
    k = 1; fss = 1;
    while (k < 4 * FL) begin tick(); k++; fss += int'(f_sync); end
    chk("ss_frames", fss, 4);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("last_stop_idle", {busy, frame_done, f_sync}, 3'b010);
    quiet("last_stop_quiet", 150);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cfg_wr = ($urandom_range(0, 7) == 0);
      cfg_addr = 2'($urandom_range(0, 3));
      cfg_data = {4'($urandom_range(0, 1)), 19'($urandom)};
      start = ($urandom_range(0, 19) == 0);
      stop = ($urandom_range(0, 299) == 0);
      last_idx = 2'($urandom_range(0, 3));
      tick();
    end
    {cfg_wr, start, stop} = '0;

    // asynchronous reset mid-line
    if (!busy) go(2'd0, 1'b0);
    ticks(30);
    #3 rst_n = 1'b0;
    #1 chk("async_reset", {busy, f_sync, sync, frame_done, entry_idx, Mode, X, Y, constVal}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ticks(20);
    chk("reset_stays_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
